// File: rtl/matrix_scan_pwm_pkg.sv
// Shared types, default sizes and counter-width helpers for the PWM matrix scanner.
package matrix_scan_pwm_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  localparam int DEF_ROWS     = 8;
  localparam int DEF_COLS     = 8;
  localparam int DEF_BPP      = 2;
  localparam int DEF_DWELL    = 16;
  localparam int SLOTS        = (1 << DEF_BPP) - 1;
  localparam int FRAME_CYCLES = DEF_ROWS * (1 + SLOTS * DEF_DWELL);

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int slots_of(input int bpp);
    return (1 << bpp) - 1;
  endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Dwell/slot/row counters; exposes the values that the next cycle will hold so the
// top can register its outputs on the same edge. No backpressure: advances whenever adv_i.
module matrix_scan_timer
  import matrix_scan_pwm_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int SLOTS_N = SLOTS,
  parameter int DWELL   = DEF_DWELL
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        clr_i,
  input  logic                        adv_i,
  output logic [cnt_w(SLOTS_N)-1:0]   slot_nxt_o,
  output logic [$clog2(ROWS)-1:0]     row_nxt_o,
  output logic                        row_end_o,
  output logic                        frame_end_nxt_o
);
  localparam int RW = $clog2(ROWS);
  localparam int SW = cnt_w(SLOTS_N);
  localparam int DW = cnt_w(DWELL);

  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [SW-1:0] r_slot, w_slot_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic          w_dwell_end;

  assign w_dwell_end = (r_dwell == DW'(DWELL - 1));
  assign row_end_o   = w_dwell_end && (r_slot == SW'(SLOTS_N - 1));

  always_comb begin
    w_dwell_nxt = r_dwell;
    w_slot_nxt  = r_slot;
    w_row_nxt   = r_row;
    if (clr_i) begin
      w_dwell_nxt = '0;
      w_slot_nxt  = '0;
      w_row_nxt   = '0;
    end else if (adv_i) begin
      if (w_dwell_end) begin
        w_dwell_nxt = '0;
        if (row_end_o) begin
          w_slot_nxt = '0;
          w_row_nxt  = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
        end else begin
          w_slot_nxt = r_slot + SW'(1);
        end
      end else begin
        w_dwell_nxt = r_dwell + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dwell <= '0;
      r_slot  <= '0;
      r_row   <= '0;
    end else begin
      r_dwell <= w_dwell_nxt;
      r_slot  <= w_slot_nxt;
      r_row   <= w_row_nxt;
    end
  end

  assign slot_nxt_o      = w_slot_nxt;
  assign row_nxt_o       = w_row_nxt;
  assign frame_end_nxt_o = (w_dwell_nxt == DW'(DWELL - 1)) && (w_slot_nxt == SW'(SLOTS_N - 1)) &&
                           (w_row_nxt == RW'(ROWS - 1));

endmodule

// File: rtl/matrix_scan_pwm.sv
// Row-scanning grey-scale LED matrix driver with double-buffered frames.
// All outputs registered (1-cycle from state); loads are never stalled, latest pending wins.
module matrix_scan_pwm
  import matrix_scan_pwm_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int BPP   = DEF_BPP,
  parameter int DWELL = DEF_DWELL
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic [ROWS*COLS*BPP-1:0]  frame_i,
  input  logic                      load_i,
  output logic                      load_ack_o,
  output logic [ROWS-1:0]           row_o,
  output logic [COLS-1:0]           col_o,
  output logic [$clog2(ROWS)-1:0]   row_idx_o,
  output logic                      frame_done_o
);
  localparam int N_SLOTS = slots_of(BPP);
  localparam int SW      = cnt_w(N_SLOTS);
  localparam int RW      = $clog2(ROWS);
  localparam int FW      = ROWS * COLS * BPP;
  localparam logic [ROWS-1:0] ROW0 = {{(ROWS-1){1'b0}}, 1'b1};

  state_e          r_state, w_state_nxt;
  logic [FW-1:0]   r_active, r_pending, w_act_nxt;
  logic            r_pend, r_ack, r_done;
  logic [ROWS-1:0] r_row;
  logic [COLS-1:0] r_col, w_col_nxt;
  logic [RW-1:0]   r_row_idx, w_row_nxt;
  logic [SW-1:0]   w_slot_nxt;
  logic            w_clr, w_adv, w_row_end, w_frame_end_nxt, w_ack_nxt;

  assign w_clr = !en_i || (r_state == IDLE);
  assign w_adv = en_i && (r_state == DRIVE);

  matrix_scan_timer #(.ROWS(ROWS), .SLOTS_N(N_SLOTS), .DWELL(DWELL)) u_timer (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .clr_i           (w_clr),
    .adv_i           (w_adv),
    .slot_nxt_o      (w_slot_nxt),
    .row_nxt_o       (w_row_nxt),
    .row_end_o       (w_row_end),
    .frame_end_nxt_o (w_frame_end_nxt)
  );

  always_comb begin
    w_state_nxt = IDLE;
    if (en_i) begin
      case (r_state)
        IDLE:    w_state_nxt = BLANK;
        BLANK:   w_state_nxt = DRIVE;
        DRIVE:   w_state_nxt = w_row_end ? BLANK : DRIVE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // An idle-side promotion can land on the BLANK->DRIVE edge, so compare against the post-promotion buffer.
  assign w_act_nxt = r_ack ? r_pending : r_active;

  always_comb begin
    w_col_nxt = '0;
    for (int c = 0; c < COLS; c++) begin
      w_col_nxt[c] = 32'(w_act_nxt[(int'(w_row_nxt) * COLS + c) * BPP +: BPP]) > 32'(w_slot_nxt);
    end
  end

  // The ack is raised for the frame_done cycle; the buffer swap happens at the end of that cycle.
  assign w_ack_nxt = ((r_state == IDLE) && load_i) ||
                     ((w_state_nxt == DRIVE) && w_frame_end_nxt && (r_pend || load_i));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_row_idx <= '0;
      r_done    <= 1'b0;
      r_ack     <= 1'b0;
      r_active  <= '0;
      r_pending <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row     <= (w_state_nxt == DRIVE) ? (ROW0 << w_row_nxt) : '0;
      r_col     <= (w_state_nxt == DRIVE) ? w_col_nxt : '0;
      r_row_idx <= w_row_nxt;
      r_done    <= (w_state_nxt == DRIVE) && w_frame_end_nxt;
      r_ack     <= w_ack_nxt;
      r_active  <= w_act_nxt;
      if (load_i) begin
        r_pending <= frame_i;
        r_pend    <= 1'b1;
      end else if (r_ack) begin
        r_pend    <= 1'b0;
      end
    end
  end

  assign load_ack_o   = r_ack;
  assign row_o        = r_row;
  assign col_o        = r_col;
  assign row_idx_o    = r_row_idx;
  assign frame_done_o = r_done;

endmodule

// File: tb/tb_matrix_scan_pwm.sv
// Directed bench for matrix_scan_pwm at default parameters.
module tb_matrix_scan_pwm;
  import matrix_scan_pwm_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [127:0] frame;
  logic         load;
  logic         ack;
  logic [7:0]   row;
  logic [7:0]   col;
  logic [2:0]   row_idx;
  logic         done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int on_cnt [8];
  int drive_len;

  always #5 clk = ~clk;

  matrix_scan_pwm dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .frame_i      (frame),
    .load_i       (load),
    .load_ack_o   (ack),
    .row_o        (row),
    .col_o        (col),
    .row_idx_o    (row_idx),
    .frame_done_o (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(output int at);
    int g;
    g = 0;
    tick();
    while (!done && g < 1000) begin
      tick();
      g++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    at = cyc;
  endtask

  task automatic measure_row(input int r);
    logic [7:0] oh;
    int g;
    oh = 8'h01 << r;
    for (int c = 0; c < 8; c++) on_cnt[c] = 0;
    drive_len = 0;
    g = 0;
    while (row != oh && g < 1000) begin
      tick();
      g++;
    end
    if (row != oh) chk("row_timeout", 64'd0, 64'd1);
    while (row == oh && drive_len < 1000) begin
      for (int c = 0; c < 8; c++) if (col[c]) on_cnt[c]++;
      drive_len++;
      tick();
    end
  endtask

  function automatic logic [127:0] with_pix(input logic [127:0] f, input int r, input int c,
                                            input logic [1:0] v);
    f[(r * 8 + c) * 2 +: 2] = v;
    return f;
  endfunction

  initial begin
    logic [127:0] f_b, f_c, f_d;
    int c1, c2, g, bad_a, early_ack;

    f_b = '1;
    f_b = with_pix(f_b, 0, 0, 2'd1);
    f_b = with_pix(f_b, 0, 1, 2'd2);
    f_b = with_pix(f_b, 0, 2, 2'd0);
    for (int c = 0; c < 8; c++) f_b = with_pix(f_b, 7, c, 2'd1);
    f_c = '1;
    for (int c = 0; c < 8; c++) f_c = with_pix(f_c, 0, c, 2'd2);
    f_d = '1;
    for (int c = 0; c < 8; c++) f_d = with_pix(f_d, 0, c, 2'd0);

    rst_n = 1'b0; en = 1'b0; load = 1'b0; frame = '0;
    repeat (3) tick();
    chk("rst_row", 64'(row), 64'h0);
    chk("rst_col", 64'(col), 64'h0);
    chk("rst_idx", 64'(row_idx), 64'h0);
    chk("rst_ack_done", 64'({ack, done}), 64'h0);
    rst_n = 1'b1;

    // Idle load: ack on the following cycle, single pulse.
    frame = '1; load = 1'b1;
    tick();
    load = 1'b0;
    chk("idle_ack", 64'(ack), 64'h1);
    tick();
    chk("idle_ack_off", 64'(ack), 64'h0);

    en = 1'b1;
    tick();
    chk("blank0_row", 64'(row), 64'h0);
    chk("blank0_col", 64'(col), 64'h0);
    measure_row(0);
    chk("row0_len", 64'(drive_len), 64'd48);
    chk("row0_on", 64'(on_cnt[5]), 64'd48);
    chk("blank1_row", 64'(row), 64'h0);
    chk("blank1_idx", 64'(row_idx), 64'd1);
    tick();
    chk("row1_drive", 64'(row), 64'h02);

    wait_done(c1);
    chk("done1_no_ack", 64'(ack), 64'h0);
    wait_done(c2);
    chk("frame_period", 64'(c2 - c1), 64'(FRAME_CYCLES));
    chk("frame_period_abs", 64'(c2 - c1), 64'd392);

    // Load frame B mid-frame; frame A must stay visible until frame_done.
    repeat (100) tick();
    frame = f_b; load = 1'b1;
    tick();
    load = 1'b0;
    bad_a = 0; early_ack = 0; g = 0;
    while (!done && g < 1000) begin
      if (row != 8'h00 && col != 8'hFF) bad_a++;
      if (ack) early_ack++;
      tick();
      g++;
    end
    chk("no_tear", 64'(bad_a), 64'd0);
    chk("no_early_ack", 64'(early_ack), 64'd0);
    chk("ack_with_done", 64'({done, ack}), 64'h3);
    chk("done_col_a", 64'(col), 64'hFF);
    tick();
    chk("ack_pulse_1", 64'(ack), 64'h0);

    measure_row(0);
    chk("b_c0", 64'(on_cnt[0]), 64'd16);
    chk("b_c1", 64'(on_cnt[1]), 64'd32);
    chk("b_c2", 64'(on_cnt[2]), 64'd0);
    chk("b_c3", 64'(on_cnt[3]), 64'd48);
    measure_row(7);
    chk("b_r7_c0", 64'(on_cnt[0]), 64'd16);
    chk("b_r7_c7", 64'(on_cnt[7]), 64'd16);

    // Drop enable at row 3 slot 1, then restart from row 0 of the same frame.
    g = 0;
    while (row != 8'h08 && g < 1000) begin
      tick();
      g++;
    end
    repeat (16) tick();
    chk("r3_idx", 64'(row_idx), 64'd3);
    chk("r3_row", 64'(row), 64'h08);
    en = 1'b0;
    tick();
    chk("dis_row_col", 64'({row, col}), 64'h0);
    chk("dis_idx_done", 64'({row_idx, done}), 64'h0);
    early_ack = 0;
    repeat (3) begin
      tick();
      if (ack) early_ack++;
    end
    en = 1'b1;
    tick();
    chk("reen_blank", 64'({row, col, row_idx}), 64'h0);
    tick();
    chk("reen_row0", 64'(row), 64'h01);
    chk("reen_col", 64'(col), 64'hFB);
    chk("reen_no_ack", 64'(early_ack + int'(ack)), 64'd0);

    // Load C, then load D exactly on the frame_done cycle that promotes C.
    frame = f_c; load = 1'b1;
    tick();
    load = 1'b0;
    chk("c_no_ack", 64'(ack), 64'h0);
    wait_done(c1);
    chk("c_ack", 64'(ack), 64'h1);
    frame = f_d; load = 1'b1;
    tick();
    load = 1'b0;
    chk("c_ack_off", 64'(ack), 64'h0);
    measure_row(0);
    chk("c_row0", 64'(on_cnt[0]), 64'd32);
    chk("c_row0_c7", 64'(on_cnt[7]), 64'd32);
    wait_done(c2);
    chk("d_ack", 64'(ack), 64'h1);
    measure_row(0);
    chk("d_row0", 64'(on_cnt[0]), 64'd0);
    chk("d_row0_len", 64'(drive_len), 64'd48);

    // Asynchronous reset in the middle of DRIVE.
    repeat (3) tick();
    chk("pre_rst_row", 64'(row), 64'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_row", 64'(row), 64'h0);
    chk("async_rst_col", 64'(col), 64'h0);
    en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", 64'({row, col, row_idx, ack, done}), 64'h0);
    en = 1'b1;
    tick();
    tick();
    chk("cleared_row", 64'(row), 64'h01);
    chk("cleared_col", 64'(col), 64'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
